// File: rtl/seg_display_scan.sv
// seg_display_scan: frame-coherent 4-digit common-anode 7-segment scanner with anti-ghost blanking
module seg_display_scan #(
    parameter int SCAN_DIV  = 250,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tenths,
    input  logic [3:0] seconds_ones,
    input  logic [3:0] seconds_tens,
    input  logic [3:0] minutes,
    input  logic       blank,
    input  logic       lzb,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    snap_t_q, snap_t_d, snap_so_q, snap_so_d, snap_st_q, snap_st_d, snap_m_q, snap_m_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d, fd_q, fd_d;
    logic          tick, load, off;
    logic [3:0]    dig;

    always_comb begin
        tick      = cnt_q == CW'(SCAN_DIV - 1);
        load      = cnt_q == '0 && idx_q == 2'd0;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        snap_t_d  = load ? tenths : snap_t_q;
        snap_so_d = load ? seconds_ones : snap_so_q;
        snap_st_d = load ? seconds_tens : snap_st_q;
        snap_m_d  = load ? minutes : snap_m_q;
        off       = blank || cnt_q < CW'(BLANK_CYC) || (idx_q == 2'd3 && lzb && snap_m_q == 4'd0);
        dig       = idx_q == 2'd0 ? snap_t_q : idx_q == 2'd1 ? snap_so_q : idx_q == 2'd2 ? snap_st_q : snap_m_q;
        an_d      = off ? 4'b1111 : ~(4'b0001 << idx_q);
        dp_d      = off | ~idx_q[0];
        fd_d      = tick && idx_q == 2'd3;
        seg_d     = 7'b0111111;
        case (dig)
            4'd0: seg_d = 7'b1000000;
            4'd1: seg_d = 7'b1111001;
            4'd2: seg_d = 7'b0100100;
            4'd3: seg_d = 7'b0110000;
            4'd4: seg_d = 7'b0011001;
            4'd5: seg_d = 7'b0010010;
            4'd6: seg_d = 7'b0000010;
            4'd7: seg_d = 7'b1111000;
            4'd8: seg_d = 7'b0000000;
            4'd9: seg_d = 7'b0010000;
            default: seg_d = 7'b0111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_t_q  <= '0;
            snap_so_q <= '0;
            snap_st_q <= '0;
            snap_m_q  <= '0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_t_q  <= snap_t_d;
            snap_so_q <= snap_so_d;
            snap_st_q <= snap_st_d;
            snap_m_q  <= snap_m_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: table vectors plus per-cycle scoreboard against a behavioural scan model
module tb_seg_display_scan;
    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0, rst = 1'b1, blank = 1'b0, lzb = 1'b0;
    logic [3:0] tenths = '0, seconds_ones = '0, seconds_tens = '0, minutes = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_done;

    seg_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .tenths(tenths), .seconds_ones(seconds_ones),
        .seconds_tens(seconds_tens), .minutes(minutes), .blank(blank), .lzb(lzb),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       seg_dc;
    } exp_t;

    typedef struct {
        logic [3:0]      m, st, so, t;
        logic            lzb;
        logic [3:0][6:0] s;
        logic            lit3;
    } vec_t;

    exp_t       sbq[$];
    vec_t       tv[4];
    int         n_cmp = 0, n_bad = 0, cyc_n = 0;
    int         m_cnt = 0, m_idx = 0, last_cnt = 0, last_idx = 0;
    logic [3:0] ms_t = '0, ms_so = '0, ms_st = '0, ms_m = '0;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d got %0h exp %0h", nm, cyc_n, got, exp);
        end
    endtask

    // Expectation for the coming edge is built from model state before that edge.
    task automatic cyc();
        exp_t       e;
        logic       off;
        logic [3:0] d;
        if (rst) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, seg_dc: 1'b0};
        end else begin
            d = m_idx == 0 ? ms_t : m_idx == 1 ? ms_so : m_idx == 2 ? ms_st : ms_m;
            off = blank || m_cnt < BC || (m_idx == 3 && lzb && ms_m == 4'd0);
            e.an = off ? 4'hF : 4'hF ^ (4'b0001 << m_idx);
            e.seg = enc(d);
            e.dp = off || m_idx == 0 || m_idx == 2;
            e.fd = m_cnt == SD - 1 && m_idx == 3;
            e.seg_dc = m_cnt == 0 && m_idx == 0;
        end
        sbq.push_back(e);
        last_cnt = m_cnt;
        last_idx = m_idx;
        if (rst) begin
            m_cnt = 0; m_idx = 0; ms_t = '0; ms_so = '0; ms_st = '0; ms_m = '0;
        end else begin
            if (m_cnt == 0 && m_idx == 0) begin
                ms_t = tenths; ms_so = seconds_ones; ms_st = seconds_tens; ms_m = minutes;
            end
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else m_cnt++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        e = sbq.pop_front();
        chk("sb_an", 32'(an), 32'(e.an));
        chk("sb_dp", 32'(dp), 32'(e.dp));
        chk("sb_fd", 32'(frame_done), 32'(e.fd));
        if (!e.seg_dc) chk("sb_seg", 32'(seg), 32'(e.seg));
    endtask

    task automatic run_until(input int c, input int ix);
        for (int k = 0; k < 4 * SD + 1 && !(m_cnt == c && m_idx == ix); k++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        int fd_cnt, n;
        tv[0] = '{4'd3, 4'd4, 4'd5, 4'd6, 1'b0, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 1'b1};
        tv[1] = '{4'd0, 4'd1, 4'd2, 4'd9, 1'b1, {7'b1000000, 7'b1111001, 7'b0100100, 7'b0010000}, 1'b0};
        tv[2] = '{4'd0, 4'd12, 4'd8, 4'd7, 1'b0, {7'b1000000, 7'b0111111, 7'b0000000, 7'b1111000}, 1'b1};
        tv[3] = '{4'd15, 4'd0, 4'd0, 4'd0, 1'b1, {7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000}, 1'b1};
        cyc();
        cyc();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            minutes = tv[i].m; seconds_tens = tv[i].st; seconds_ones = tv[i].so; tenths = tv[i].t;
            lzb = tv[i].lzb;
            run_until(0, 0);
            fd_cnt = 0;
            for (int k = 0; k < 4 * SD; k++) begin
                cyc();
                if (frame_done === 1'b1) fd_cnt++;
                if (last_cnt == 4) begin
                    chk("tv_seg", 32'(seg), 32'(tv[i].s[last_idx]));
                    chk("tv_an", 32'(an), (last_idx == 3 && !tv[i].lit3) ? 32'hF : 32'(4'hF ^ (4'b0001 << last_idx)));
                    chk("tv_dp", 32'(dp), (last_idx == 3 && !tv[i].lit3) ? 32'd1 : 32'(last_idx % 2 == 0));
                end
            end
            chk("tv_fd_per_frame", 32'(fd_cnt), 32'd1);
        end
        // snapshot coherence: tenths changes mid-frame, visible only next frame
        minutes = 4'd3; seconds_tens = 4'd4; seconds_ones = 4'd5; tenths = 4'd6; lzb = 1'b0;
        run_until(0, 0);
        cyc();
        run_until(0, 2);
        tenths = 4'd7;
        run_until(0, 0);
        for (int k = 0; k < 5; k++) cyc();
        chk("coh_next_frame", 32'(seg), 32'(7'b1111000));
        // blank for 5 cycles mid-slot
        run_until(2, 1);
        blank = 1'b1;
        cyc();
        chk("blank_an", 32'(an), 32'hF);
        chk("blank_dp", 32'(dp), 32'd1);
        for (int k = 0; k < 4; k++) cyc();
        blank = 1'b0;
        cyc();
        chk("blank_rec_an", 32'(an), 32'(4'b1101));
        chk("blank_rec_dp", 32'(dp), 32'd0);
        // reset mid-scan at idx 2, cnt 5
        run_until(5, 2);
        rst = 1'b1;
        cyc();
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_dp", 32'(dp), 32'd1);
        chk("mrst_fd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n++;
            if (an !== 4'hF) break;
        end
        chk("mrst_first_lit", 32'(n), 32'(BC + 1));
        chk("mrst_first_an", 32'(an), 32'(4'b1110));
        for (int k = 0; k < 8 * SD; k++) begin
            if (k % (2 * SD) == 0) begin
                minutes = 4'($urandom_range(0, 15)); seconds_tens = 4'($urandom_range(0, 15));
                seconds_ones = 4'($urandom_range(0, 15)); tenths = 4'($urandom_range(0, 15));
                lzb = 1'($urandom_range(0, 1));
            end
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
